scrypt_blockmix: RTL and testbench



---
 rtl/scrypt_blockmix.sv | 185 ++++++++++++++++++
 tb/tb_scrypt_blockmix.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scrypt_blockmix.sv
// scrypt_blockmix: BlockMix_salsa20_8 control and datapath for r = 1.
// Splits a 1024-bit block B = (B0, B1) into two sequential jobs for one
// salsa20_8 core: Y0 = Salsa(B1 ^ B0), Y1 = Salsa(Y0 ^ B1), B' = (Y0, Y1).
// Optional build macro BLOCKMIX_TIMEOUT_EN adds a wait-state watchdog that
// aborts a job after SALSA_TIMEOUT cycles without salsa_done and pulses error.
module scrypt_blockmix #(
    parameter int SALSA_TIMEOUT = 64,
    parameter int CNT_W         = 8
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [1023:0] block_in,
    output logic          busy,
    output logic          done,
    output logic [1023:0] block_out,
    output logic          error,
    output logic          salsa_enable,
    output logic [511:0]  salsa_data,
    input  logic [511:0]  salsa_out,
    input  logic          salsa_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // The watchdog may only fire when the limit is representable in the
    // counter; otherwise a truncated compare value would abort far too early.
    localparam bit TIMEOUT_CFG_OK = (SALSA_TIMEOUT >= 1) && (SALSA_TIMEOUT < (1 << CNT_W));

    state_t         r_state;
    state_t         w_state_nxt;
    logic [511:0]   r_b1;
    logic [511:0]   w_b1_nxt;
    logic [511:0]   r_y0;
    logic [511:0]   w_y0_nxt;
    logic [511:0]   r_salsa_data;
    logic [511:0]   w_salsa_data_nxt;
    logic [1023:0]  r_block_out;
    logic [1023:0]  w_block_out_nxt;
    logic           r_busy;
    logic           w_busy_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           r_error;
    logic           w_error_nxt;
    logic           r_salsa_enable;
    logic           w_salsa_enable_nxt;
    logic           w_timeout;
    logic           w_abort;

`ifdef BLOCKMIX_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    // Wait-cycle counter: zero outside the WAIT states, +1 for every WAIT cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == ST_WAIT0) || (r_state == ST_WAIT1)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= {CNT_W{1'b0}};
        end
    end

    // The limit is reached in the SALSA_TIMEOUT-th WAIT cycle; a salsa_done
    // arriving in that same cycle takes priority over the abort.
    assign w_timeout = ((r_state == ST_WAIT0) || (r_state == ST_WAIT1))
                     && (r_cnt == CNT_W'(SALSA_TIMEOUT - 1))
                     && !salsa_done;
`else
    assign w_timeout = 1'b0;
`endif

    assign w_abort = w_timeout & TIMEOUT_CFG_OK;

    // Next-state and next-output logic; every register holds unless a state acts.
    // salsa_data is loaded on the edge that enters an ISSUE state so that data
    // and the one-cycle enable pulse are presented together in that state.
    // Only B1 is retained: B0 is needed solely for the first XOR at accept time.
    always_comb begin
        w_state_nxt        = r_state;
        w_b1_nxt           = r_b1;
        w_y0_nxt           = r_y0;
        w_salsa_data_nxt   = r_salsa_data;
        w_block_out_nxt    = r_block_out;
        w_busy_nxt         = r_busy;
        w_done_nxt         = 1'b0;
        w_error_nxt        = 1'b0;
        w_salsa_enable_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt        = ST_ISSUE0;
                    w_b1_nxt           = block_in[1023:512];
                    w_salsa_data_nxt   = block_in[1023:512] ^ block_in[511:0];
                    w_salsa_enable_nxt = 1'b1;
                    w_busy_nxt         = 1'b1;
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            ST_ISSUE0: begin
                w_state_nxt = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (salsa_done) begin
                    w_state_nxt        = ST_ISSUE1;
                    w_y0_nxt           = salsa_out;
                    w_salsa_data_nxt   = salsa_out ^ r_b1;
                    w_salsa_enable_nxt = 1'b1;
                end else if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_WAIT0;
                end
            end
            ST_ISSUE1: begin
                w_state_nxt = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (salsa_done) begin
                    w_state_nxt     = ST_FINISH;
                    w_block_out_nxt = {salsa_out, r_y0};
                    w_done_nxt      = 1'b1;
                end else if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_WAIT1;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything, discarding partial work.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= ST_IDLE;
            r_b1           <= 512'd0;
            r_y0           <= 512'd0;
            r_salsa_data   <= 512'd0;
            r_block_out    <= 1024'd0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_salsa_enable <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_b1           <= w_b1_nxt;
            r_y0           <= w_y0_nxt;
            r_salsa_data   <= w_salsa_data_nxt;
            r_block_out    <= w_block_out_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_error        <= w_error_nxt;
            r_salsa_enable <= w_salsa_enable_nxt;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign block_out    = r_block_out;
    assign error        = r_error;
    assign salsa_enable = r_salsa_enable;
    assign salsa_data   = r_salsa_data;

endmodule

// File: tb/tb_scrypt_blockmix.sv
// tb_scrypt_blockmix: scoreboard bench for scrypt_blockmix with a behavioural
// salsa core stub (configurable latency; output ~data or a salsa20/8 model).
module tb_scrypt_blockmix;

    localparam int TO_LIMIT = 64;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic [1023:0] block_in;
    logic          busy;
    logic          done;
    logic [1023:0] block_out;
    logic          error;
    logic          salsa_enable;
    logic [511:0]  salsa_data;
    logic [511:0]  salsa_out;
    logic          salsa_done;

    scrypt_blockmix #(.SALSA_TIMEOUT(TO_LIMIT), .CNT_W(8)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .block_in(block_in),
        .busy(busy), .done(done), .block_out(block_out), .error(error),
        .salsa_enable(salsa_enable), .salsa_data(salsa_data),
        .salsa_out(salsa_out), .salsa_done(salsa_done)
    );

    typedef struct {
        logic [1023:0] out;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   stub_mode = 0;
    int   stub_lat  = 4;
    bit   stub_mute = 1'b0;
    int   spur_req  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] salsa8(input logic [511:0] din);
        logic [31:0]  x [16];
        logic [31:0]  w [16];
        logic [511:0] r;
        int qi [8][4];
        int ia, ib, ic, id;
        qi = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11},
               '{0, 1, 2, 3}, '{5, 6, 7, 4}, '{10, 11, 8, 9}, '{15, 12, 13, 14}};
        for (int i = 0; i < 16; i++) begin
            w[i] = din[32*i +: 32];
            x[i] = w[i];
        end
        for (int dr = 0; dr < 4; dr++) begin
            for (int q = 0; q < 8; q++) begin
                ia = qi[q][0]; ib = qi[q][1]; ic = qi[q][2]; id = qi[q][3];
                x[ib] = x[ib] ^ rotl(x[ia] + x[id], 7);
                x[ic] = x[ic] ^ rotl(x[ib] + x[ia], 9);
                x[id] = x[id] ^ rotl(x[ic] + x[ib], 13);
                x[ia] = x[ia] ^ rotl(x[id] + x[ic], 18);
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + w[i];
        return r;
    endfunction

    function automatic logic [511:0] core_f(input int mode, input logic [511:0] din);
        return (mode == 0) ? ~din : salsa8(din);
    endfunction

    function automatic logic [1023:0] ref_blockmix(input int mode, input logic [1023:0] b);
        logic [511:0] b0, b1, y0, y1;
        b0 = b[511:0];
        b1 = b[1023:512];
        y0 = core_f(mode, b1 ^ b0);
        y1 = core_f(mode, y0 ^ b1);
        return {y1, y0};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- salsa core stub ----------------
    initial begin : stub
        logic [511:0] cap;
        int cnt;
        bit pending;
        int spur_seen;
        salsa_done = 1'b0;
        salsa_out  = 512'd0;
        pending    = 1'b0;
        cnt        = 0;
        spur_seen  = 0;
        cap        = 512'd0;
        forever begin
            @(posedge clk);
            #1;
            salsa_done = 1'b0;
            if (!n_rst) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    check_vec("data_stable", salsa_data, cap);
                    cnt--;
                    if (cnt == 0) begin
                        salsa_done = 1'b1;
                        salsa_out  = core_f(stub_mode, cap);
                        pending    = 1'b0;
                    end
                end
                if (spur_req != spur_seen) begin
                    spur_seen  = spur_req;
                    salsa_done = 1'b1;
                    salsa_out  = rand512();
                end
                if (salsa_enable) begin
                    cap     = salsa_data;
                    pending = !stub_mute;
                    cnt     = stub_lat;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [1023:0] exp_hold;
        int bcnt;
        int en_cnt;
        exp_t e;
        exp_hold = 1024'd0;
        bcnt     = 0;
        en_cnt   = 0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                exp_hold = 1024'd0;
                bcnt     = 0;
                en_cnt   = 0;
            end else begin
                if (salsa_enable) en_cnt++;
                if (busy) bcnt++;
                else bcnt = 0;
                if (done) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1 expected no pending job");
                    end else begin
                        e = sb.pop_front();
                        check_vec("result_y0", block_out[511:0], e.out[511:0]);
                        check_vec("result_y1", block_out[1023:512], e.out[1023:512]);
                        check_int("latency", bcnt, 2 * e.lat + 3);
                        check_int("enable_pulses", en_cnt, 2);
                        exp_hold = e.out;
                    end
                    en_cnt = 0;
                end
                if (error) en_cnt = 0;
                check_vec("hold_lo", block_out[511:0], exp_hold[511:0]);
                check_vec("hold_hi", block_out[1023:512], exp_hold[1023:512]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [1023:0] blk);
        block_in = blk;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic issue(input int mode, input int lat, input logic [1023:0] blk);
        exp_t e;
        stub_mode = mode;
        stub_lat  = lat;
        e.out     = ref_blockmix(mode, blk);
        e.lat     = lat;
        sb.push_back(e);
        do_start(blk);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        check_int("idle_within_budget", int'(busy), 0);
    endtask

    task automatic check_all_zero(input string name);
        check_int({name, "_ctrl"}, int'({busy, done, error, salsa_enable}), 0);
        check_vec({name, "_sdata"}, salsa_data, 512'd0);
        check_vec({name, "_out_lo"}, block_out[511:0], 512'd0);
        check_vec({name, "_out_hi"}, block_out[1023:512], 512'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [1023:0] basic;
        logic [511:0]  ones;
        int tc;
        n_rst    = 1'b0;
        start    = 1'b0;
        block_in = 1024'd0;
        #1;
        check_all_zero("reset");
        repeat (3) tick();
        n_rst = 1'b1;
        tick();

        // Basic: B0 = 0, B1 word i = i, stub output ~data, L = 4.
        for (int i = 0; i < 16; i++) begin
            basic[32*i +: 32]       = 32'd0;
            basic[512 + 32*i +: 32] = i;
        end
        ones = '1;
        issue(0, 4, basic);
        check_int("issue0_enable", int'(salsa_enable), 1);
        check_vec("issue0_data", salsa_data, basic[1023:512]);
        check_int("busy_after_accept", int'(busy), 1);
        tick();
        check_int("enable_one_cycle", int'(salsa_enable), 0);
        repeat (4) tick();
        check_int("issue1_enable", int'(salsa_enable), 1);
        check_vec("issue1_data", salsa_data, ones);
        repeat (5) tick();
        check_int("done_at_2L_plus_3", int'(done), 1);
        tick();
        check_int("done_one_cycle", int'(done), 0);
        check_int("busy_dropped", int'(busy), 0);

        // Start pulsed again in WAIT0 with a different block is ignored.
        issue(0, 4, basic);
        tick();
        tick();
        block_in = {rand512(), rand512()};
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_idle(40);

        // Spurious salsa_done in IDLE, then in ISSUE0.
        tick();
        spur_req++;
        repeat (3) tick();
        check_int("spurious_idle_busy", int'(busy), 0);
        spur_req++;
        issue(1, 3, {rand512(), rand512()});
        wait_idle(40);

        // Randomized jobs: random block, core model, latency and gap.
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(3, 0)) tick();
            issue(int'($urandom_range(1, 0)), int'($urandom_range(6, 1)), {rand512(), rand512()});
            wait_idle(40);
        end

        // Reset in WAIT1, then a fresh job.
        tick();
        issue(0, 4, {rand512(), rand512()});
        repeat (7) tick();
        n_rst = 1'b0;
        sb.delete();
        #1;
        check_all_zero("midop_reset");
        tick();
        check_int("enable_low_in_reset", int'(salsa_enable), 0);
        tick();
        n_rst = 1'b1;
        tick();
        check_int("enable_low_after_reset", int'(salsa_enable), 0);
        issue(1, 2, {rand512(), rand512()});
        wait_idle(40);

        // Core never answers.
        tick();
        stub_mute = 1'b1;
        do_start({rand512(), rand512()});
`ifdef BLOCKMIX_TIMEOUT_EN
        tc = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (error === 1'b1) begin
                tc = c;
                break;
            end
        end
        check_int("timeout_cycle", tc, TO_LIMIT + 1);
        check_int("timeout_no_done", int'(done), 0);
        check_int("timeout_busy_low", int'(busy), 0);
        tick();
        check_int("error_one_cycle", int'(error), 0);
        stub_mute = 1'b0;
`else
        tc = 0;
        repeat (150) tick();
        check_int("no_timeout_busy", int'(busy), 1);
        check_int("no_timeout_error", int'(error) + tc, 0);
        stub_mute = 1'b0;
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
`endif
        issue(0, 5, {rand512(), rand512()});
        wait_idle(40);
        tick();
        check_int("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
